// File: rtl/data_mem_responder_if.sv
// Core data-memory port plus host dump stream for data_mem_responder.
// The master modport is the core/host side; the slave modport is the responder.
interface data_mem_responder_if #(
   parameter int unsigned DATA_W = 32
);
   logic              MemWrite;
   logic [31:0]       ALUResult;
   logic [DATA_W-1:0] WriteData;
   logic [1:0]        MemorySelector;
   logic              Finished;
   logic [DATA_W-1:0] ReadData;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;
   logic              dump_done;
   logic              access_err;

   modport master (
      output MemWrite, ALUResult, WriteData, MemorySelector, Finished, dump_ready,
      input  ReadData, dump_valid, dump_data, dump_last, dump_done, access_err
   );

   modport slave (
      input  MemWrite, ALUResult, WriteData, MemorySelector, Finished, dump_ready,
      output ReadData, dump_valid, dump_data, dump_last, dump_done, access_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Three-bank data memory for the single-cycle core; streams the output bank to the host
// once the core finishes. Define DUMP_CHECKSUM_EN to append a 32-bit sum beat to the dump.
module data_mem_responder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);
   localparam int unsigned Depth = 1 << ADDR_W;
`ifdef DUMP_CHECKSUM_EN
   localparam logic [ADDR_W:0] LastPtr = (ADDR_W+1)'(Depth);
`else
   localparam logic [ADDR_W:0] LastPtr = (ADDR_W+1)'(Depth - 1);
`endif

   typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

   state_e            state_q;
   logic [ADDR_W:0]   ptr_q;
   logic [ADDR_W:0]   ptr_inc;
   logic              dump_valid_q;
   logic              dump_last_q;
   logic              dump_done_q;
   logic              access_err_q;
   logic [DATA_W-1:0] beat_data;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
`endif

   logic [DATA_W-1:0] bank_in  [Depth];
   logic [DATA_W-1:0] bank_scr [Depth];
   logic [DATA_W-1:0] bank_out [Depth];

   logic [ADDR_W-1:0] widx;
   logic              aligned;
   logic              mapped;
   logic              store_en;
   logic              store_bad;

   // Address bits above ADDR_W+1 are deliberately dropped, so the banks alias.
   assign widx      = bus.ALUResult[ADDR_W+1:2];
   assign aligned   = (bus.ALUResult[1:0] == 2'b00);
   assign mapped    = (bus.MemorySelector != 2'd3);
   assign store_en  = (state_q == StRun) && bus.MemWrite && aligned && mapped;
   assign store_bad = (state_q == StRun) && bus.MemWrite && !(aligned && mapped);
   assign ptr_inc   = ptr_q + 1'b1;

   // Banks carry no reset so program results survive a board reset.
   always_ff @(posedge clk) begin
      if (store_en) begin
         case (bus.MemorySelector)
            2'd0:    bank_in[widx]  <= bus.WriteData;
            2'd1:    bank_scr[widx] <= bus.WriteData;
            2'd2:    bank_out[widx] <= bus.WriteData;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.ReadData = '0;
      case (bus.MemorySelector)
         2'd0:    bus.ReadData = bank_in[widx];
         2'd1:    bus.ReadData = bank_scr[widx];
         2'd2:    bus.ReadData = bank_out[widx];
         default: bus.ReadData = '0;
      endcase
   end

   always_comb begin
      beat_data = bank_out[ptr_q[ADDR_W-1:0]];
`ifdef DUMP_CHECKSUM_EN
      if (ptr_q[ADDR_W]) beat_data = sum_q;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StRun;
         ptr_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_last_q  <= 1'b0;
         dump_done_q  <= 1'b0;
         access_err_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         if (store_bad) access_err_q <= 1'b1;
         unique case (state_q)
            StRun: begin
               if (bus.Finished) begin
                  state_q      <= StDump;
                  ptr_q        <= '0;
                  dump_valid_q <= 1'b1;
                  dump_last_q  <= (LastPtr == '0);
`ifdef DUMP_CHECKSUM_EN
                  sum_q        <= '0;
`endif
               end
            end
            StDump: begin
               // dump_valid is always high here, so ready alone marks a transfer.
               if (bus.dump_ready) begin
                  if (ptr_q == LastPtr) begin
                     state_q      <= StDone;
                     dump_valid_q <= 1'b0;
                     dump_last_q  <= 1'b0;
                     dump_done_q  <= 1'b1;
                  end else begin
                     ptr_q       <= ptr_inc;
                     dump_last_q <= (ptr_inc == LastPtr);
`ifdef DUMP_CHECKSUM_EN
                     sum_q       <= sum_q + beat_data;
`endif
                  end
               end
            end
            StDone: ;
            default: state_q <= StRun;
         endcase
      end
   end

   assign bus.dump_valid = dump_valid_q;
   assign bus.dump_last  = dump_last_q;
   assign bus.dump_done  = dump_done_q;
   assign bus.access_err = access_err_q;
   assign bus.dump_data  = dump_valid_q ? beat_data : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=4): vector table for bank access,
// hand sequences for dump, back-pressure, mid-dump reset and store-with-finish.
module tb_data_mem_responder;
`ifdef DUMP_CHECKSUM_EN
   localparam int NBeats = 17;
`else
   localparam int NBeats = 16;
`endif

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;

   data_mem_responder_if #(.DATA_W(32)) bus ();

   data_mem_responder #(
      .ADDR_W (4),
      .DATA_W (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_beat(input int idx);
      return (idx < 16) ? 32'(idx + 1) : 32'd136;
   endfunction

   initial begin
      int idx;
      int cyc;
      bit xfer;
      bit stored;

      vecs[0]  = '{1'b1, 2'd0, 32'h10,  32'h1111_1111, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{1'b1, 2'd2, 32'h10,  32'h2222_2222, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{1'b1, 2'd1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 2'd1, 32'h10,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b0, 2'd0, 32'h10,  32'h0,         1'b1, 32'h1111_1111, 1'b0};
      vecs[5]  = '{1'b0, 2'd2, 32'h10,  32'h0,         1'b1, 32'h2222_2222, 1'b0};
      vecs[6]  = '{1'b0, 2'd1, 32'h110, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[7]  = '{1'b0, 2'd1, 32'h13,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[8]  = '{1'b1, 2'd3, 32'h10,  32'h3333_3333, 1'b1, 32'h0,         1'b1};
      vecs[9]  = '{1'b1, 2'd1, 32'h13,  32'h4444_4444, 1'b1, 32'hDEAD_BEEF, 1'b1};
      vecs[10] = '{1'b0, 2'd1, 32'h10,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
      vecs[11] = '{1'b0, 2'd0, 32'h10,  32'h0,         1'b1, 32'h1111_1111, 1'b1};
      vecs[12] = '{1'b0, 2'd3, 32'h10,  32'h0,         1'b1, 32'h0,         1'b1};

      reset              = 1'b0;
      bus.MemWrite       = 1'b0;
      bus.ALUResult      = '0;
      bus.WriteData      = '0;
      bus.MemorySelector = '0;
      bus.Finished       = 1'b0;
      bus.dump_ready     = 1'b0;

      #12;
      check("rst_valid", 32'(bus.dump_valid), 32'd0);
      check("rst_last",  32'(bus.dump_last),  32'd0);
      check("rst_done",  32'(bus.dump_done),  32'd0);
      check("rst_err",   32'(bus.access_err), 32'd0);
      check("rst_data",  bus.dump_data,       32'd0);
      tick();
      reset = 1'b1;

      // Bank access table: read checked before the edge, sticky error after it.
      for (int i = 0; i < 13; i++) begin
         bus.MemWrite       = vecs[i].we;
         bus.MemorySelector = vecs[i].sel;
         bus.ALUResult      = vecs[i].addr;
         bus.WriteData      = vecs[i].wdata;
         #1;
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.ReadData, vecs[i].exp_rd);
         tick();
         check($sformatf("vec%0d_err", i), 32'(bus.access_err), 32'(vecs[i].exp_err));
      end
      bus.MemWrite = 1'b0;

      for (int i = 0; i < 16; i++) begin
         bus.MemWrite       = 1'b1;
         bus.MemorySelector = 2'd2;
         bus.ALUResult      = 32'(i * 4);
         bus.WriteData      = 32'(i + 1);
         tick();
      end
      bus.MemWrite   = 1'b0;
      bus.Finished   = 1'b1;
      bus.dump_ready = 1'b1;
      tick();
      bus.Finished = 1'b0;
      for (int b = 0; b < NBeats; b++) begin
         check($sformatf("full_valid%0d", b), 32'(bus.dump_valid), 32'd1);
         check($sformatf("full_data%0d", b),  bus.dump_data,       exp_beat(b));
         check($sformatf("full_last%0d", b),  32'(bus.dump_last),  32'(b == NBeats - 1));
         tick();
      end
      check("full_done",      32'(bus.dump_done),  32'd1);
      check("full_valid_end", 32'(bus.dump_valid), 32'd0);
      tick();
      check("done_sticky", 32'(bus.dump_done), 32'd1);

      // Reset, then dump under random back-pressure with a store attempted mid-dump.
      reset = 1'b0;
      #1;
      check("rst_async_done", 32'(bus.dump_done), 32'd0);
      tick();
      reset        = 1'b1;
      bus.Finished = 1'b1;
      tick();
      bus.Finished = 1'b0;
      idx    = 0;
      cyc    = 0;
      stored = 1'b0;
      while (idx < NBeats && cyc < 200) begin
         bus.dump_ready = 1'($urandom_range(0, 1));
         if (idx == 2 && !stored) begin
            bus.MemWrite       = 1'b1;
            bus.MemorySelector = 2'd2;
            bus.ALUResult      = 32'd12;
            bus.WriteData      = 32'h0000_0BAD;
            stored             = 1'b1;
         end else begin
            bus.MemWrite = 1'b0;
         end
         #1;
         check("bp_valid", 32'(bus.dump_valid), 32'd1);
         check($sformatf("bp_data%0d", idx), bus.dump_data, exp_beat(idx));
         check($sformatf("bp_last%0d", idx), 32'(bus.dump_last), 32'(idx == NBeats - 1));
         xfer = bus.dump_ready;
         tick();
         if (xfer) idx++;
         cyc++;
      end
      bus.MemWrite = 1'b0;
      check("bp_count", 32'(idx), 32'(NBeats));
      check("bp_done",  32'(bus.dump_done), 32'd1);
      bus.MemorySelector = 2'd2;
      bus.ALUResult      = 32'd12;
      #1;
      check("bp_store_dropped", bus.ReadData, 32'd4);

      // Reset asserted while beat 5 is presented.
      reset = 1'b0;
      tick();
      reset          = 1'b1;
      bus.dump_ready = 1'b1;
      bus.Finished   = 1'b1;
      tick();
      bus.Finished = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check("beat5_data", bus.dump_data, 32'd6);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.dump_valid), 32'd0);
      check("midrst_last",  32'(bus.dump_last),  32'd0);
      check("midrst_done",  32'(bus.dump_done),  32'd0);
      check("midrst_data",  bus.dump_data,       32'd0);
      tick();
      reset        = 1'b1;
      bus.Finished = 1'b1;
      tick();
      bus.Finished = 1'b0;
      check("restart_valid", 32'(bus.dump_valid), 32'd1);
      check("restart_data",  bus.dump_data,       32'd1);

      // Misaligned store alone; banks must survive the resets.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mis_err_before", 32'(bus.access_err), 32'd0);
      bus.MemWrite       = 1'b1;
      bus.MemorySelector = 2'd1;
      bus.ALUResult      = 32'h13;
      bus.WriteData      = 32'h9999_9999;
      tick();
      bus.MemWrite  = 1'b0;
      bus.ALUResult = 32'h10;
      #1;
      check("mis_err_after", 32'(bus.access_err), 32'd1);
      check("mis_retained",  bus.ReadData,        32'hDEAD_BEEF);

      // Store and Finished on the same edge.
      bus.MemWrite       = 1'b1;
      bus.MemorySelector = 2'd2;
      bus.ALUResult      = 32'h0;
      bus.WriteData      = 32'h55;
      bus.Finished       = 1'b1;
      tick();
      bus.MemWrite = 1'b0;
      bus.Finished = 1'b0;
      check("same_edge_valid", 32'(bus.dump_valid), 32'd1);
      check("same_edge_data",  bus.dump_data,       32'h55);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the single-cycle ARM core: serves the core's data-memory requests (`MemWrite`, address on `ALUResult`, `WriteData`, `MemorySelector`) from three word-addressed RAM banks.
- Returns `ReadData` to the core.
- Once the core raises `Finished`, streams the output bank to an external host over a valid/ready port.
- Sits between the core's data-memory outputs and the board/host interface.

## Interface

Parameters:
- `ADDR_W`, 8: word-address width per bank; bank depth = 2^ADDR_W words.
- `DATA_W`, 32: word width; must match the core.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe from core.
- `ALUResult`  in  32  byte address from core; word index = `ALUResult[ADDR_W+1:2]`.
- `WriteData`  in  32  store data from core.
- `MemorySelector`  in  2  bank select: 0 = input bank, 1 = scratch bank, 2 = output bank, 3 = unmapped.
- `Finished`  in  1  program-complete flag from core.
- `ReadData`  out  32  load data to core.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  host accepts beat.
- `dump_data`  out  32  dump beat payload.
- `dump_last`  out  1  final beat of dump.
- `dump_done`  out  1  dump complete; sticky until reset.
- `access_err`  out  1  sticky: unmapped or misaligned access seen.

## Operation

- FSM states: RUN, DUMP, DONE. Reset state is RUN.
- RUN:
  - Store: on a rising edge with `MemWrite`=1, `MemorySelector`≤2 and `ALUResult[1:0]`=0, the selected bank word is written with `WriteData`.
  - Load: `ReadData` = selected bank at word index (combinational read).
  - Selector 3: `ReadData`=0; store dropped; `access_err` set.
  - Misaligned address (`ALUResult[1:0]`≠0) with `MemWrite`=1: store dropped; `access_err` set. Reads ignore `ALUResult[1:0]`.
  - Upper address bits above `ADDR_W+1` are ignored (aliasing).
  - `Finished`=1 sampled on a rising edge → DUMP; dump pointer cleared to 0.
- DUMP:
  - All core stores are ignored; `ReadData` still serves reads.
  - `dump_valid`=1; `dump_data` = output bank[ptr].
  - Beat transfers on an edge with `dump_valid` & `dump_ready`; ptr increments.
  - `dump_last`=1 on the final beat.
  - Transfer of the final beat → DONE.
  - `Finished` deasserting mid-dump has no effect.
- DONE:
  - `dump_valid`=0, `dump_done`=1. Stores are ignored.
  - Stays in DONE until reset.
- RAM banks are not reset; contents are retained across reset.

## Timing

- Reset values: FSM=RUN, ptr=0, `dump_valid`=0, `dump_last`=0, `dump_done`=0, `access_err`=0, `dump_data`=0.
- `ReadData` is combinational from the address and selector inputs (zero-cycle latency, as the single-cycle core requires).
- A store becomes visible to a read in the cycle after the write edge.
- `Finished` high at edge N → `dump_valid`=1 in cycle N+1, carrying word 0.
- Store and `Finished` in the same cycle: the store commits at that edge and is included in the dump.
- With `dump_ready` held at 1, one beat transfers per cycle. A full dump takes 2^ADDR_W cycles (+1 with checksum).
- `dump_data` is stable while `dump_valid`=1 and `dump_ready`=0.
- ptr is `ADDR_W`+1 bits wide and never wraps: the dump stops after the last beat.
- Reset asserted mid-dump: immediate return to RUN with all outputs at their reset values. The next `Finished` restarts the dump at word 0.

## Configuration

- `DUMP_CHECKSUM_EN` defined:
  - After output word 2^ADDR_W−1, one extra beat carries the 32-bit sum (mod 2^32) of all dumped words.
  - `dump_last` is asserted on the checksum beat only.
- Not defined: the dump ends at word 2^ADDR_W−1, with `dump_last` on that beat. No checksum logic is present.

## Test plan

- Write 0xDEADBEEF to selector 1, address 0x10; read back the same address → `ReadData`=0xDEADBEEF the next cycle. Selector 0 and 2 at that address remain unchanged.
- Store with selector 3, then a store to address 0x13 → both dropped; `access_err`=1 and stays 1. Selector 3 read returns 0.
- Fill output bank word i = i+1 (`ADDR_W`=4); raise `Finished` with `dump_ready`=1 → 16 consecutive beats 1..16, `dump_last` on the 16th, `dump_done`=1 one cycle later. With `DUMP_CHECKSUM_EN`: a 17th beat = 136, carrying `dump_last`.
- During the dump, toggle `dump_ready` 1/0 randomly → no beat lost or duplicated, and `dump_data` is held while stalled. A store issued mid-dump is not written.
- Assert reset at beat 5 of the dump → outputs return to reset values immediately. Re-raising `Finished` yields beat 0 = 1 again.
- Store and `Finished` in the same cycle to output word 0 with value 0x55 → first dump beat = 0x55.
